// File: rtl/serv_wb_arb_pkg.sv
// rtl/serv_wb_arb_pkg.sv - shared types and constants for the SERV Wishbone arbiter
package serv_wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_t;

    localparam logic [3:0] IBUS_SEL = 4'hF;

endpackage

// File: rtl/serv_wb_arb_wdog.sv
// rtl/serv_wb_arb_wdog.sv - stall watchdog that force-completes a granted transfer
module serv_wb_arb_wdog #(
    parameter int TIMEOUT_W = 4
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expire
);
    // wdog counts stall cycles already completed, so expiry lands on the (2**W-1)th stall cycle
    localparam int LAST_I = 2**TIMEOUT_W - 2;
    localparam logic [TIMEOUT_W-1:0] LAST = LAST_I[TIMEOUT_W-1:0];

    logic [TIMEOUT_W-1:0] wdog;

    assign o_expire = i_run && (wdog == LAST);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wdog <= '0;
        end else if (i_clr || o_expire) begin
            wdog <= '0;
        end else if (i_run) begin
            wdog <= wdog + 1'b1;
        end
    end

endmodule

// File: rtl/serv_wb_arbiter.sv
// rtl/serv_wb_arbiter.sv - shares one Wishbone-classic port between SERV ibus and dbus
module serv_wb_arbiter #(
    parameter int DBUS_MAX  = 2,
    parameter int TIMEOUT_W = 4
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_timeout,
    output logic        o_timeout_seen
);
    import serv_wb_arb_pkg::*;

    localparam int CNT_W = $clog2(DBUS_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = DBUS_MAX[CNT_W-1:0];

    arb_state_t       state;
    logic [CNT_W-1:0] dbus_cnt;
    logic             gnt_i;
    logic             gnt_d;
    logic             master_cyc;
    logic             expire;

    assign gnt_i      = (state == ARB_GNT_I);
    assign gnt_d      = (state == ARB_GNT_D);
    assign master_cyc = (gnt_i && i_ibus_cyc) || (gnt_d && i_dbus_cyc);

    // Watchdog only runs while the granted master still wants the bus and no ack arrives
    serv_wb_arb_wdog #(.TIMEOUT_W(TIMEOUT_W)) u_wdog (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_run    (master_cyc && !i_wb_ack),
        .i_clr    (!master_cyc || i_wb_ack),
        .o_expire (expire)
    );

    assign o_ibus_ack = gnt_i && i_ibus_cyc && (i_wb_ack || expire);
    assign o_dbus_ack = gnt_d && i_dbus_cyc && (i_wb_ack || expire);
    assign o_ibus_rdt = (gnt_i && i_ibus_cyc && i_wb_ack) ? i_wb_rdt : 32'h0;
    assign o_dbus_rdt = (gnt_d && i_dbus_cyc && i_wb_ack) ? i_wb_rdt : 32'h0;

    assign o_wb_cyc  = (gnt_i || gnt_d) && !expire;
    assign o_wb_adr  = gnt_d ? i_dbus_adr : i_ibus_adr;
    assign o_wb_dat  = gnt_d ? i_dbus_dat : 32'h0;
    assign o_wb_sel  = gnt_d ? i_dbus_sel : IBUS_SEL;
    assign o_wb_we   = gnt_d && i_dbus_we;
    assign o_timeout = expire;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= ARB_IDLE;
            dbus_cnt       <= '0;
            o_timeout_seen <= 1'b0;
        end else begin
            if (expire) begin
                o_timeout_seen <= 1'b1;
            end
            case (state)
                ARB_IDLE: begin
                    // dbus wins unless ibus is waiting and dbus has used up its streak
                    if (i_dbus_cyc && (!i_ibus_cyc || dbus_cnt < CNT_MAX)) begin
                        state    <= ARB_GNT_D;
                        dbus_cnt <= i_ibus_cyc ? dbus_cnt + 1'b1 : '0;
                    end else if (i_ibus_cyc) begin
                        state    <= ARB_GNT_I;
                        dbus_cnt <= '0;
                    end
                end
                default: begin
                    if (!master_cyc || i_wb_ack || expire) begin
                        state <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
